// File: rtl/chess_clock_core_pkg.sv
// rtl/chess_clock_core_pkg.sv - state encodings, BCD time constants and BCD arithmetic helpers
// Times are packed {mm, ss} in BCD; arithmetic goes through small binary conversions.
package chess_clock_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FLAG  = 3'd4
  } state_e;

  localparam logic [15:0] ZERO_TIME     = 16'h0000;
  localparam logic [15:0] ONE_SEC_LEFT  = 16'h0001;
  localparam logic [7:0]  DEFAULT_START = 8'h05;
  localparam logic [15:0] DEFAULT_TIME  = {DEFAULT_START, 8'h00};

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

  function automatic logic [15:0] bcd_dec1(input logic [15:0] t);
    logic [7:0] m;
    logic [7:0] s;
    if (t[7:0] == 8'h00) begin
      m = bin2bcd(bcd2bin(t[15:8]) - 7'd1);
      s = 8'h59;
    end else begin
      m = t[15:8];
      s = bin2bcd(bcd2bin(t[7:0]) - 7'd1);
    end
    return {m, s};
  endfunction

  // Seconds carry into minutes; anything past max_bcd:59 pins there.
  function automatic logic [15:0] bcd_add_sec(input logic [15:0] t, input logic [5:0] inc,
                                              input logic [7:0] max_bcd);
    logic [6:0] s;
    logic [6:0] m;
    s = bcd2bin(t[7:0]) + 7'(inc);
    m = bcd2bin(t[15:8]);
    if (s >= 7'd60) begin
      s = s - 7'd60;
      m = m + 7'd1;
    end
    if (m > bcd2bin(max_bcd)) begin
      return {max_bcd, 8'h59};
    end
    return {bin2bcd(m), bin2bcd(s)};
  endfunction

  function automatic logic [7:0] bcd_inc_min(input logic [7:0] m, input logic [7:0] max_bcd);
    return (m == max_bcd) ? 8'h01 : bin2bcd(bcd2bin(m) + 7'd1);
  endfunction

endpackage

// File: rtl/chess_clock_core_bcd_time_cell.sv
// rtl/chess_clock_core_bcd_time_cell.sv - one player's BCD mm:ss register with load, decrement and increment
// Priority: load over increment over decrement; a zero time never decrements.
module bcd_time_cell
  import chess_clock_core_pkg::*;
#(
  parameter logic [7:0] MAX_MIN_BCD = 8'h99
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        dec1_i,
  input  logic        add_inc_i,
  input  logic [5:0]  inc_sec_i,
  output logic [15:0] time_o,
  output logic        expiring_o
);

  logic [15:0] time_q;
  logic [15:0] time_d;

  always_comb begin
    time_d = time_q;
    if (load_i) begin
      time_d = load_val_i;
    end else if (add_inc_i) begin
      time_d = bcd_add_sec(time_q, inc_sec_i, MAX_MIN_BCD);
    end else if (dec1_i && (time_q != ZERO_TIME)) begin
      time_d = bcd_dec1(time_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      time_q <= DEFAULT_TIME;
    end else begin
      time_q <= time_d;
    end
  end

  assign time_o     = time_q;
  assign expiring_o = (time_q == ONE_SEC_LEFT);

endmodule

// File: rtl/chess_clock_core.sv
// rtl/chess_clock_core.sv - N-player chess clock: FSM, 1 Hz prescaler, turn rotation, start-minute setup
// Each player's time lives in a bcd_time_cell; this level decides who decrements, increments or loads.
module chess_clock_core
  import chess_clock_core_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CLK_HZ      = 100_000_000,
  parameter int MAX_MIN     = 99,
  parameter int PW          = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      enable_i,
  input  logic                      set_i,
  input  logic                      add_i,
  input  logic                      turn_end_i,
  input  logic [5:0]                inc_sec_i,
  output logic [PW-1:0]             active_o,
  output logic [7:0]                start_min_o,
  output logic [16*NUM_PLAYERS-1:0] times_o,
  output logic [NUM_PLAYERS-1:0]    flag_o,
  output logic [2:0]                state_o
);

  localparam int              PRW         = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRW-1:0]  PRESC_LAST  = PRW'(CLK_HZ - 1);
  localparam logic [7:0]      MAX_MIN_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic [PW-1:0]   LAST_PLAYER = PW'(NUM_PLAYERS - 1);

  state_e                   state_q, state_d;
  logic [PRW-1:0]           presc_q, presc_d;
  logic [PW-1:0]            active_q, active_d;
  logic [7:0]               start_min_q, start_min_d;
  logic [NUM_PLAYERS-1:0]   flag_q, flag_d;

  logic [NUM_PLAYERS-1:0]   expiring;
  logic                     in_run, turn_acc, tick, act_expiring, expire;
  logic                     enter_run_from_set, enter_set, load_all;

  assign in_run             = (state_q == ST_RUN);
  assign turn_acc           = in_run && turn_end_i;
  // A turn_end on the tick edge swallows that tick.
  assign tick               = in_run && (presc_q == PRESC_LAST) && !turn_acc;
  assign expire             = tick && act_expiring;
  assign enter_run_from_set = (state_q == ST_SET) && (state_d == ST_RUN);
  assign enter_set          = (state_q != ST_SET) && (state_d == ST_SET);
  assign load_all           = (state_d == ST_SET) || enter_run_from_set;

  always_comb begin
    act_expiring = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (active_q == PW'(i)) act_expiring = expiring[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (set_i) state_d = ST_SET;
      ST_SET:   if (enable_i) state_d = ST_RUN;
      ST_RUN: begin
        if (expire) state_d = ST_FLAG;
        else if (!enable_i) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (set_i) state_d = ST_SET;
        else if (enable_i) state_d = ST_RUN;
      end
      ST_FLAG:  if (set_i) state_d = ST_SET;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    presc_d     = presc_q;
    active_d    = active_q;
    start_min_d = start_min_q;
    flag_d      = flag_q;
    if (enter_run_from_set || turn_acc) begin
      presc_d = '0;
    end else if (in_run) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRW'(1);
    end
    if (enter_run_from_set) begin
      active_d = '0;
    end else if (turn_acc) begin
      active_d = (active_q == LAST_PLAYER) ? '0 : active_q + PW'(1);
    end
    if ((state_q == ST_SET) && add_i) begin
      start_min_d = bcd_inc_min(start_min_q, MAX_MIN_BCD);
    end
    if (enter_set) begin
      flag_d = '0;
    end else if (expire) begin
      flag_d = flag_q | (NUM_PLAYERS'(1) << active_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q     <= '0;
      active_q    <= '0;
      start_min_q <= DEFAULT_START;
      flag_q      <= '0;
    end else begin
      presc_q     <= presc_d;
      active_q    <= active_d;
      start_min_q <= start_min_d;
      flag_q      <= flag_d;
    end
  end

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_cell
    bcd_time_cell #(
      .MAX_MIN_BCD(MAX_MIN_BCD)
    ) u_cell (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .load_i     (load_all),
      .load_val_i ({start_min_d, 8'h00}),
      .dec1_i     (tick && (active_q == PW'(i))),
      .add_inc_i  (turn_acc && (active_q == PW'(i))),
      .inc_sec_i  (inc_sec_i),
      .time_o     (times_o[16*i +: 16]),
      .expiring_o (expiring[i])
    );
  end

  always_comb begin
    state_o     = state_q;
    active_o    = active_q;
    start_min_o = start_min_q;
    flag_o      = flag_q;
  end

endmodule

// File: tb/tb_chess_clock_core.sv
// tb/tb_chess_clock_core.sv - table-driven scoreboard bench for a 3-player, 4 Hz chess clock
module tb_chess_clock_core;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        set = 1'b0;
  logic        add = 1'b0;
  logic        turn_end = 1'b0;
  logic [5:0]  inc_sec = 6'd0;
  logic [1:0]  active;
  logic [7:0]  start_min;
  logic [47:0] times;
  logic [2:0]  flag;
  logic [2:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_step = 0;

  always #5 clk = ~clk;

  chess_clock_core #(
    .NUM_PLAYERS(3),
    .CLK_HZ     (4),
    .MAX_MIN    (99),
    .PW         (2)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (enable),
    .set_i       (set),
    .add_i       (add),
    .turn_end_i  (turn_end),
    .inc_sec_i   (inc_sec),
    .active_o    (active),
    .start_min_o (start_min),
    .times_o     (times),
    .flag_o      (flag),
    .state_o     (state)
  );

  typedef struct {
    logic        rst, set, add, te, en;
    logic [5:0]  inc;
    int          ncyc;
    logic [2:0]  st;
    logic [1:0]  act;
    logic [7:0]  smin;
    logic [2:0]  flg;
    logic [47:0] tm;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic s, input logic a, input logic te,
                              input logic en, input logic [5:0] inc, input int ncyc,
                              input logic [2:0] st, input logic [1:0] act, input logic [7:0] smin,
                              input logic [2:0] flg, input logic [47:0] tm);
    vec_t v;
    v.rst = rst; v.set = s; v.add = a; v.te = te; v.en = en; v.inc = inc; v.ncyc = ncyc;
    v.st = st; v.act = act; v.smin = smin; v.flg = flg; v.tm = tm;
    return v;
  endfunction

  function automatic logic [47:0] t3(input logic [15:0] p2, input logic [15:0] p1,
                                     input logic [15:0] p0);
    return {p2, p1, p0};
  endfunction

  task automatic cmp(input string name, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, n_step, got, exp);
    end
  endtask

  task automatic check_front();
    vec_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard step %0d: got empty queue expected entry", n_step);
      return;
    end
    e = sb.pop_front();
    cmp("state", 48'(state), 48'(e.st));
    cmp("active", 48'(active), 48'(e.act));
    cmp("start_min", 48'(start_min), 48'(e.smin));
    cmp("flag", 48'(flag), 48'(e.flg));
    cmp("times", times, e.tm);
  endtask

  // Pulses last one clock edge; enable is a level held until the next step.
  task automatic step(input vec_t v);
    sb.push_back(v);
    reset = v.rst; set = v.set; add = v.add; turn_end = v.te; enable = v.en; inc_sec = v.inc;
    @(posedge clk); #1;
    reset = 1'b0; set = 1'b0; add = 1'b0; turn_end = 1'b0;
    repeat (v.ncyc - 1) begin
      @(posedge clk); #1;
    end
    check_front();
    n_step++;
  endtask

  task automatic pulse_add();
    add = 1'b1;
    @(posedge clk); #1;
    add = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  localparam logic [2:0] I = 3'd0, S = 3'd1, R = 3'd2, P = 3'd3, F = 3'd4;

  initial begin
    tbl.push_back(mk(1,0,0,0,0,0, 1, I,0,8'h05,3'b000, t3(16'h0500,16'h0500,16'h0500)));
    tbl.push_back(mk(0,0,0,0,1,0, 1, I,0,8'h05,3'b000, t3(16'h0500,16'h0500,16'h0500)));
    tbl.push_back(mk(0,0,1,0,0,0, 1, I,0,8'h05,3'b000, t3(16'h0500,16'h0500,16'h0500)));
    tbl.push_back(mk(0,1,0,0,0,0, 1, S,0,8'h05,3'b000, t3(16'h0500,16'h0500,16'h0500)));
    tbl.push_back(mk(0,0,1,0,0,0, 1, S,0,8'h06,3'b000, t3(16'h0600,16'h0600,16'h0600)));
    tbl.push_back(mk(0,0,1,0,0,0, 1, S,0,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0700)));
    tbl.push_back(mk(0,0,0,0,1,0, 1, R,0,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0700)));
    tbl.push_back(mk(0,0,0,0,1,0,20, R,0,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0655)));
    tbl.push_back(mk(0,0,0,1,1,10,1, R,1,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,1,1,0, 1, R,2,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,1,1,0, 1, R,0,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,0,1,0, 2, R,0,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,1,1,0, 1, R,1,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,0,1,0, 3, R,1,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,1,1,0, 1, R,2,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,0,1,0, 4, R,2,8'h07,3'b000, t3(16'h0659,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,0,1,0, 2, R,2,8'h07,3'b000, t3(16'h0659,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,0,0,0,10, P,2,8'h07,3'b000, t3(16'h0659,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,0,1,0, 1, R,2,8'h07,3'b000, t3(16'h0659,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,0,1,0, 1, R,2,8'h07,3'b000, t3(16'h0658,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,0,0,0,0, 1, P,2,8'h07,3'b000, t3(16'h0658,16'h0700,16'h0705)));
    tbl.push_back(mk(0,0,1,1,0,0, 1, P,2,8'h07,3'b000, t3(16'h0658,16'h0700,16'h0705)));
    tbl.push_back(mk(0,1,1,0,0,0, 1, S,2,8'h07,3'b000, t3(16'h0700,16'h0700,16'h0700)));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
    end

    // Walk start_min 07 -> 99, then check saturation of the Fischer increment.
    for (int k = 0; k < 91; k++) pulse_add();
    step(mk(0,0,1,0,0,0, 1, S,2,8'h99,3'b000, t3(16'h9900,16'h9900,16'h9900)));
    step(mk(0,0,0,0,1,0, 1, R,0,8'h99,3'b000, t3(16'h9900,16'h9900,16'h9900)));
    step(mk(0,0,0,1,1,55,1, R,1,8'h99,3'b000, t3(16'h9900,16'h9900,16'h9955)));
    step(mk(0,0,0,1,1,0, 1, R,2,8'h99,3'b000, t3(16'h9900,16'h9900,16'h9955)));
    step(mk(0,0,0,1,1,0, 1, R,0,8'h99,3'b000, t3(16'h9900,16'h9900,16'h9955)));
    step(mk(0,0,0,1,1,10,1, R,1,8'h99,3'b000, t3(16'h9900,16'h9900,16'h9959)));
    step(mk(0,0,0,0,0,0, 1, P,1,8'h99,3'b000, t3(16'h9900,16'h9900,16'h9959)));
    step(mk(0,1,0,0,0,0, 1, S,1,8'h99,3'b000, t3(16'h9900,16'h9900,16'h9900)));
    step(mk(0,0,1,0,0,0, 1, S,1,8'h01,3'b000, t3(16'h0100,16'h0100,16'h0100)));

    // One minute on player 0 runs out; times freeze and only set leaves FLAG.
    step(mk(0,0,0,0,1,0, 1, R,0,8'h01,3'b000, t3(16'h0100,16'h0100,16'h0100)));
    step(mk(0,0,0,0,1,0,236,R,0,8'h01,3'b000, t3(16'h0100,16'h0100,16'h0001)));
    step(mk(0,0,0,0,1,0, 4, F,0,8'h01,3'b001, t3(16'h0100,16'h0100,16'h0000)));
    step(mk(0,0,0,1,1,0, 8, F,0,8'h01,3'b001, t3(16'h0100,16'h0100,16'h0000)));
    step(mk(0,1,0,0,0,0, 1, S,0,8'h01,3'b000, t3(16'h0100,16'h0100,16'h0100)));

    step(mk(0,0,0,0,1,0, 1, R,0,8'h01,3'b000, t3(16'h0100,16'h0100,16'h0100)));
    step(mk(0,0,0,0,1,0, 6, R,0,8'h01,3'b000, t3(16'h0100,16'h0100,16'h0059)));
    step(mk(1,0,0,0,1,0, 1, I,0,8'h05,3'b000, t3(16'h0500,16'h0500,16'h0500)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
